// File: rtl/calc_pkg.sv
// ============================================================================
//  Module   : calc_pkg
//  Purpose  : Shared types and helpers for the binary-to-BCD conversion path.
//             Provides the converter state enum, the BCD digit type and the
//             scratch-digit sizing function.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    // Converter sequencing states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // One packed BCD digit.
    typedef logic [3:0] bcd_digit_t;

    // Number of BCD digits needed to hold any WIDTH-bit unsigned value:
    // ceil(width * log10(2)). log10(2) is approximated as 0.30103, which is
    // exact enough for every practical width (10 digits for width 32).
    function automatic int scratch_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

`default_nettype wire

// File: rtl/operand_to_bcd_if.sv
// ============================================================================
//  Module   : operand_to_bcd_if
//  Purpose  : Bundle between the operand source and the BCD converter.
//  Ports    : bin      - unsigned operand (master -> slave)
//             start    - conversion request (master -> slave)
//             digits   - BCD digits, digits[0] = ones (slave -> master)
//             overflow - last value was >= 10^DIGITS (slave -> master)
//             busy     - conversion in progress (slave -> master)
//             done     - one-cycle pulse, new digits valid (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface operand_to_bcd_if
    import calc_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 4
);

    logic [WIDTH-1:0]        bin;
    logic                    start;
    bcd_digit_t [DIGITS-1:0] digits;
    logic                    overflow;
    logic                    busy;
    logic                    done;

    modport master (
        output bin,
        output start,
        input  digits,
        input  overflow,
        input  busy,
        input  done
    );

    modport slave (
        input  bin,
        input  start,
        output digits,
        output overflow,
        output busy,
        output done
    );

endinterface

`default_nettype wire

// File: rtl/bcd_add3.sv
// ============================================================================
//  Module   : bcd_add3
//  Purpose  : Double-dabble digit correction. Adds 3 to a BCD digit of 5 or
//             more so that the following left shift carries into the next
//             decimal digit correctly. Purely combinational.
//  Ports    : d - input digit
//             y - corrected digit
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add3
    import calc_pkg::*;
(
    input  wire bcd_digit_t d,
    output bcd_digit_t      y
);

    // Digits only ever reach 9 before correction, so the 4-bit sum never wraps.
    assign y = (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;

endmodule

`default_nettype wire

// File: rtl/operand_to_bcd.sv
// ============================================================================
//  Module   : operand_to_bcd
//  Purpose  : Sequential binary-to-BCD converter (shift-and-add-3). Converts
//             the full WIDTH-bit operand one bit per clock and exports the
//             DIGITS least-significant decimal digits plus an overflow flag.
//             Output digits change only on completion, all at once.
//  Ports    : clk     - system clock, rising edge
//             reset_n - asynchronous active-low reset
//             bus     - operand_to_bcd_if slave (bin, start, digits,
//                       overflow, busy, done)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_to_bcd
    import calc_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 4,
    parameter bit AUTO   = 1'b1
)(
    input  wire logic       clk,
    input  wire logic       reset_n,
    operand_to_bcd_if.slave bus
);

    localparam int SD    = scratch_digits(WIDTH);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t                  r_state;
    logic [WIDTH-1:0]        r_shift;
    logic [WIDTH-1:0]        r_last_bin;
    logic [4*SD-1:0]         r_scratch;
    logic [CNT_W-1:0]        r_cnt;
    bcd_digit_t [DIGITS-1:0] r_digits;
    logic                    r_overflow;
    logic                    r_busy;
    logic                    r_done;

    logic [4*SD-1:0]         w_adj;
    logic [4*SD+WIDTH-1:0]   w_shifted;
    logic [4*SD-1:0]         w_next_scratch;
    logic [WIDTH-1:0]        w_next_shift;
    logic                    w_high_nz;
    logic                    w_trigger;

    // Per-digit add-3 correction ahead of the shift.
    generate
        for (genvar gi = 0; gi < SD; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .d (r_scratch[4*gi +: 4]),
                .y (w_adj[4*gi +: 4])
            );
        end
    endgenerate

    // Adjusted scratch and binary shift register move left together as one word.
    assign w_shifted      = {w_adj, r_shift} << 1;
    assign w_next_scratch = w_shifted[4*SD+WIDTH-1:WIDTH];
    assign w_next_shift   = w_shifted[WIDTH-1:0];

    // Any nonzero digit beyond the exported ones means value >= 10^DIGITS.
    always_comb begin
        w_high_nz = 1'b0;
        for (int i = DIGITS; i < SD; i++) begin
            w_high_nz = w_high_nz | (w_next_scratch[4*i +: 4] != 4'd0);
        end
    end

    // An explicit start and an AUTO change in the same cycle collapse into one request.
    assign w_trigger = bus.start | (AUTO & (bus.bin != r_last_bin));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_last_bin <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_digits   <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_state    <= SHIFT;
                        r_shift    <= bus.bin;
                        r_last_bin <= bus.bin;
                        r_scratch  <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_next_scratch;
                    r_shift   <= w_next_shift;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_STEP) begin
                        // Final shift: publish digits and flag in the same edge.
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_digits   <= w_next_scratch[4*DIGITS-1:0];
                        r_overflow <= w_high_nz;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.digits   = r_digits;
    assign bus.overflow = r_overflow;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_operand_to_bcd.sv
// ============================================================================
//  Module   : tb_operand_to_bcd
//  Purpose  : Self-checking bench for operand_to_bcd. One instance with
//             AUTO=1 and one with AUTO=0; results are compared against an
//             arithmetic reference (mod / divide by ten).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_to_bcd;
    import calc_pkg::*;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    bit   sel_auto = 1'b0;

    always #5 clk = ~clk;

    operand_to_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus_a ();
    operand_to_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus_m ();

    operand_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS), .AUTO(1'b1)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a.slave)
    );

    operand_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS), .AUTO(1'b0)) dut_m (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_m.slave)
    );

    // Observed outputs of whichever instance is under test.
    logic [15:0] w_digits;
    logic        w_ovf, w_busy, w_done;
    assign w_digits = sel_auto ? bus_a.digits   : bus_m.digits;
    assign w_ovf    = sel_auto ? bus_a.overflow : bus_m.overflow;
    assign w_busy   = sel_auto ? bus_a.busy     : bus_m.busy;
    assign w_done   = sel_auto ? bus_a.done     : bus_m.done;

    // Reference: low four decimal digits as {thousands, hundreds, tens, ones}.
    function automatic logic [15:0] ref_digits(input longint unsigned v);
        longint unsigned m;
        m = v % 64'd10000;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic ref_ovf(input longint unsigned v);
        return (v >= 64'd10000);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next edge is the accepting edge E0; returns edges until done and busy samples.
    task automatic run(output int lat, output int bc);
        tick();
        bus_m.start = 1'b0;
        bc  = w_busy ? 1 : 0;
        lat = 0;
        while (!w_done && lat < 100) begin
            tick();
            lat++;
            if (w_busy) bc++;
        end
    endtask

    task automatic check_result(input string tag, input longint unsigned v,
                                input int lat, input int bc);
        check({tag, " latency"},  32'(lat), 32'(WIDTH));
        check({tag, " busy_len"}, 32'(bc),  32'(WIDTH));
        check({tag, " digits"},   32'(w_digits), 32'(ref_digits(v)));
        check({tag, " overflow"}, 32'(w_ovf),    32'(ref_ovf(v)));
        check({tag, " busy_end"}, 32'(w_busy),   32'd0);
    endtask

    task automatic convert(input string tag, input longint unsigned v);
        int lat, bc;
        if (sel_auto) begin
            bus_a.bin = v[WIDTH-1:0];
        end else begin
            bus_m.bin   = v[WIDTH-1:0];
            bus_m.start = 1'b1;
        end
        run(lat, bc);
        check_result(tag, v, lat, bc);
        tick();
        check({tag, " done_pulse"}, 32'(w_done), 32'd0);
    endtask

    initial begin
        int lat, bc, dones, done_at;
        longint unsigned v, prev;

        bus_a.bin = '0; bus_a.start = 1'b0;
        bus_m.bin = '0; bus_m.start = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("rst a digits", 32'(bus_a.digits), 32'd0);
        check("rst a ovf",    32'(bus_a.overflow), 32'd0);
        check("rst a busy",   32'(bus_a.busy), 32'd0);
        check("rst a done",   32'(bus_a.done), 32'd0);
        check("rst m digits", 32'(bus_m.digits), 32'd0);
        check("rst m busy",   32'(bus_m.busy), 32'd0);
        reset_n = 1'b1;
        repeat (4) tick();
        check("auto idle bin0", 32'(bus_a.busy), 32'd0);

        // AUTO conversion of 1234.
        sel_auto = 1'b1;
        convert("auto1234", 64'd1234);

        // AUTO: bin changes mid-conversion, picked up afterwards.
        bus_a.bin = 32'd7;
        tick();
        dones = 0; done_at = 0;
        for (int k = 1; k <= WIDTH; k++) begin
            tick();
            if (w_done) begin dones++; done_at = k; end
            if (k == 9) bus_a.bin = 32'd58;
        end
        check("chg done_at", 32'(done_at), 32'(WIDTH));
        check("chg dones",   32'(dones), 32'd1);
        check("chg digits7", 32'(w_digits), 32'(ref_digits(64'd7)));
        tick();
        check("chg reaccept", 32'(w_busy), 32'd1);
        lat = 0;
        while (!w_done && lat < 100) begin tick(); lat++; end
        check("chg lat2",     32'(lat), 32'(WIDTH));
        check("chg digits58", 32'(w_digits), 32'(ref_digits(64'd58)));
        tick();

        // Manual conversions, including overflow boundaries.
        sel_auto = 1'b0;
        convert("man9999",  64'd9999);
        convert("man10000", 64'd10000);
        convert("manmax",   64'd4294967295);
        convert("man0",     64'd0);

        // start pulses during a conversion are ignored.
        bus_m.bin = 32'd42; bus_m.start = 1'b1;
        tick();
        bus_m.start = 1'b0;
        dones = 0; done_at = 0;
        for (int k = 1; k <= WIDTH; k++) begin
            tick();
            if (w_done) begin dones++; done_at = k; end
            bus_m.start = (k == 4 || k == 19);
        end
        check("ign done_at", 32'(done_at), 32'(WIDTH));
        check("ign dones",   32'(dones), 32'd1);
        check("ign digits",  32'(w_digits), 32'(ref_digits(64'd42)));
        bus_m.bin = 32'd5; bus_m.start = 1'b1;
        tick();
        bus_m.start = 1'b0;
        check("next accept", 32'(w_busy), 32'd1);
        lat = 0;
        while (!w_done && lat < 100) begin tick(); lat++; end
        check("next lat",    32'(lat), 32'(WIDTH));
        check("next digits", 32'(w_digits), 32'(ref_digits(64'd5)));
        tick();

        // Random manual conversions.
        for (int i = 0; i < 8; i++) begin
            v = (i % 2 == 0) ? longint'($urandom) : longint'($urandom_range(0, 19999));
            convert($sformatf("manrand%0d", i), v);
        end

        // Asynchronous reset mid-conversion on the AUTO instance.
        sel_auto = 1'b1;
        bus_a.bin = 32'd3210;
        tick();
        repeat (15) tick();
        reset_n = 1'b0;
        #1;
        check("arst busy",   32'(bus_a.busy), 32'd0);
        check("arst digits", 32'(bus_a.digits), 32'd0);
        check("arst ovf",    32'(bus_a.overflow), 32'd0);
        check("arst done",   32'(bus_a.done), 32'd0);
        check("arst m dig",  32'(bus_m.digits), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        run(lat, bc);
        check_result("arst restart", 64'd3210, lat, bc);
        tick();

        // Random AUTO conversions.
        prev = 64'd3210;
        for (int i = 0; i < 6; i++) begin
            v = longint'($urandom);
            if (v == prev) v = v ^ 64'd1;
            convert($sformatf("autorand%0d", i), v);
            prev = v;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
